// File: rtl/demux_3x16.sv
// ---------------------------------------------------------------------------
// demux_3x16 -- registered 1-to-3 demultiplexer for the 16-bit result bus.
//
// A transfer offered on the shared bus (valid_in/ready_out handshake) is
// steered by sel_in into one of three destination holding registers:
//   sel 00 -> d0, 01 -> d1, 10 -> d2, 11 -> discard (counted, no write).
// Each destination has a full flag that is set on write and cleared by the
// consumer acknowledge ack_in[i]. A write in the same cycle as an ack wins.
//
// Build option (macro DEMUX3_STALL_EN):
//   defined   : back-pressure; ready_out drops while the target is full and
//               not being acked. ovf_out does not exist.
//   undefined : overwrite; ready_out is tied high and a write into a full,
//               un-acked destination pulses ovf_out for one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears all state and data)
//   sel_in     destination select
//   d_in       bus data, WIDTH bits
//   valid_in   transfer offered
//   ready_out  transfer accepted this cycle (combinational, no d_in path)
//   ack_in     per-destination consumer acknowledge
//   d0/1/2_out destination holding registers
//   full_out   per-destination "holds unconsumed data" flags
//   ovf_out    overwrite pulse (overwrite build only)
//   count_out  accepted-transfer counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module demux_3x16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       ack_in,
  output logic [WIDTH-1:0] d0_out,
  output logic [WIDTH-1:0] d1_out,
  output logic [WIDTH-1:0] d2_out,
  output logic [2:0]       full_out,
`ifndef DEMUX3_STALL_EN
  output logic             ovf_out,
`endif
  output logic [CNT_W-1:0] count_out
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } dst_state_e;

  dst_state_e       state_q [0:2];
  dst_state_e       state_d [0:2];
  logic [WIDTH-1:0] data_q  [0:2];
  logic [WIDTH-1:0] data_d  [0:2];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [2:0]       full;
  logic [2:0]       wr;
  logic             accept;
`ifndef DEMUX3_STALL_EN
  logic             ovf_q;
  logic             ovf_d;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      full[i] = (state_q[i] == ST_FULL);
    end
  end

  // Handshake. Sel 11 is never blocked; in stall mode a real destination
  // blocks only while it is full and its consumer is not draining it now.
`ifdef DEMUX3_STALL_EN
  always_comb begin
    ready_out = 1'b1;
    if (valid_in && (sel_in != 2'b11)) begin
      ready_out = !(full[sel_in] && !ack_in[sel_in]);
    end
  end
`else
  assign ready_out = 1'b1;
`endif

  assign accept = valid_in && ready_out;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wr[i] = accept && (sel_in == 2'(i));
    end
  end

  // Per-destination two-state FSM and holding register next values.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      case (state_q[i])
        ST_EMPTY: if (wr[i]) state_d[i] = ST_FULL;
        ST_FULL: begin
          if (wr[i])          state_d[i] = ST_FULL;
          else if (ack_in[i]) state_d[i] = ST_EMPTY;
        end
        default: state_d[i] = ST_EMPTY;
      endcase
      if (wr[i]) data_d[i] = d_in;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(accept);
  end

`ifndef DEMUX3_STALL_EN
  // Overwrite: a write landing on data the consumer has not taken.
  always_comb begin
    ovf_d = |(wr & full & ~ack_in);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_EMPTY;
        data_q[i]  <= '0;
      end
      count_q <= '0;
`ifndef DEMUX3_STALL_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
      count_q <= count_d;
`ifndef DEMUX3_STALL_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign d0_out    = data_q[0];
  assign d1_out    = data_q[1];
  assign d2_out    = data_q[2];
  assign full_out  = full;
  assign count_out = count_q;
`ifndef DEMUX3_STALL_EN
  assign ovf_out   = ovf_q;
`endif

endmodule

// File: tb/tb_demux_3x16.sv
module tb_demux_3x16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_in;
  logic [15:0] d_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  ack_in;
  logic [15:0] d0_out, d1_out, d2_out;
  logic [2:0]  full_out;
  logic [7:0]  count_out;
`ifndef DEMUX3_STALL_EN
  logic        ovf_out;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  demux_3x16 #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_in    (sel_in),
    .d_in      (d_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .ack_in    (ack_in),
    .d0_out    (d0_out),
    .d1_out    (d1_out),
    .d2_out    (d2_out),
    .full_out  (full_out),
`ifndef DEMUX3_STALL_EN
    .ovf_out   (ovf_out),
`endif
    .count_out (count_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [2:0] ef, input logic [7:0] ec);
    check({tag, ".d0"},    32'(d0_out),    32'(e0));
    check({tag, ".d1"},    32'(d1_out),    32'(e1));
    check({tag, ".d2"},    32'(d2_out),    32'(e2));
    check({tag, ".full"},  32'(full_out),  32'(ef));
    check({tag, ".count"}, 32'(count_out), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; sel_in = 2'b00; d_in = 16'h0; valid_in = 1'b0; ack_in = 3'b000;
    tick(); tick();
    rst = 1'b0;
    check_regs("reset", 16'h0, 16'h0, 16'h0, 3'b000, 8'd0);
    check("reset.ready", 32'(ready_out), 32'd1);
`ifndef DEMUX3_STALL_EN
    check("reset.ovf", 32'(ovf_out), 32'd0);
`endif

    // Ack on an empty destination and bus activity without valid: no effect.
    ack_in = 3'b001; d_in = 16'hDEAD; sel_in = 2'b00;
    tick();
    ack_in = 3'b000;
    check_regs("idle", 16'h0, 16'h0, 16'h0, 3'b000, 8'd0);

    // Write 0x1234 to d0.
    sel_in = 2'b00; d_in = 16'h1234; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check_regs("wr_d0", 16'h1234, 16'h0, 16'h0, 3'b001, 8'd1);
`ifndef DEMUX3_STALL_EN
    check("wr_d0.ovf", 32'(ovf_out), 32'd0);
`endif

    // Discard 0xFFFF for three cycles.
    sel_in = 2'b11; d_in = 16'hFFFF; valid_in = 1'b1;
    check("discard.ready", 32'(ready_out), 32'd1);
    tick(); tick(); tick();
    valid_in = 1'b0;
    check_regs("discard", 16'h1234, 16'h0, 16'h0, 3'b001, 8'd4);

    // Fill d1 with 0xAAAA.
    sel_in = 2'b01; d_in = 16'hAAAA; valid_in = 1'b1;
    tick();
    check_regs("fill_d1", 16'h1234, 16'hAAAA, 16'h0, 3'b011, 8'd5);

    // Offer 0x5555 to full d1 without ack.
    d_in = 16'h5555;
    #1;
`ifdef DEMUX3_STALL_EN
    check("stall.ready0", 32'(ready_out), 32'd0);
    tick();
    check_regs("stall.hold", 16'h1234, 16'hAAAA, 16'h0, 3'b011, 8'd5);
    check("stall.ready1", 32'(ready_out), 32'd0);
    ack_in = 3'b010;
    #1;
    check("stall.ready_ack", 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0; ack_in = 3'b000;
    check_regs("stall.done", 16'h1234, 16'h5555, 16'h0, 3'b011, 8'd6);
`else
    check("ovw.ready", 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    check_regs("ovw.done", 16'h1234, 16'h5555, 16'h0, 3'b011, 8'd6);
    check("ovw.ovf_pulse", 32'(ovf_out), 32'd1);
    tick();
    check("ovw.ovf_end", 32'(ovf_out), 32'd0);
`endif

    // Fill d2, then write and ack d2 in the same cycle.
    sel_in = 2'b10; d_in = 16'h1111; valid_in = 1'b1;
    tick();
    check_regs("fill_d2", 16'h1234, 16'h5555, 16'h1111, 3'b111, 8'd7);
    d_in = 16'h0F0F; ack_in = 3'b100;
    #1;
    check("wr_ack.ready", 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0; ack_in = 3'b000;
    check_regs("wr_ack", 16'h1234, 16'h5555, 16'h0F0F, 3'b111, 8'd8);
`ifndef DEMUX3_STALL_EN
    check("wr_ack.ovf", 32'(ovf_out), 32'd0);
`endif

    // Counter wrap: 248 more accepted transfers bring 8 back to 0.
    sel_in = 2'b11; d_in = 16'h0000; valid_in = 1'b1;
    for (int i = 0; i < 247; i++) tick();
    check("wrap.255", 32'(count_out), 32'd255);
    tick();
    valid_in = 1'b0;
    check_regs("wrap.0", 16'h1234, 16'h5555, 16'h0F0F, 3'b111, 8'd0);

    // Reset during an offered write to full d0 (stalled in stall build).
    sel_in = 2'b00; d_in = 16'hBEEF; valid_in = 1'b1;
    #1;
`ifdef DEMUX3_STALL_EN
    check("rst_stall.ready", 32'(ready_out), 32'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    check_regs("rst_mid", 16'h0, 16'h0, 16'h0, 3'b000, 8'd0);
    check("rst_mid.ready", 32'(ready_out), 32'd1);
`ifndef DEMUX3_STALL_EN
    check("rst_mid.ovf", 32'(ovf_out), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux_3x16.md
# demux_3x16

Registered 1-to-3 demultiplexer for the 16-bit datapath bus. It is the write-side counterpart of the three-way source-select mux. A value driven on the shared bus is steered, under a valid/ready handshake, into one of three 16-bit destination holding registers. Each destination has a full flag that is cleared by its consumer's acknowledge. The block sits between the result bus and the three downstream consumers (register write port, memory data register, output port).

## Interface
Parameters:
- `WIDTH`, 16, data width of the bus and of each destination register.
- `CNT_W`, 8, width of the accepted-transfer counter.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sel_in`  in  2  destination select: 00 = d0, 01 = d1, 10 = d2, 11 = discard.
- `d_in`  in  WIDTH  bus data.
- `valid_in`  in  1  a transfer is offered this cycle.
- `ready_out`  out  1  the transfer is accepted this cycle; combinational.
- `ack_in`  in  3  per-destination consumer acknowledge; bit i clears `full_out[i]`.
- `d0_out`, `d1_out`, `d2_out`  out  WIDTH  destination holding registers.
- `full_out`  out  3  per-destination "holds unconsumed data" flags.
- `ovf_out`  out  1  overwrite pulse; exists only with the macro undefined.
- `count_out`  out  CNT_W  number of accepted transfers, modulo 2^CNT_W.

## Operation
- Accept condition:
  - accept = `valid_in` && `ready_out`.
  - Sel 11 is always ready. An accepted sel-11 transfer writes nothing but is still counted.
- Write on accept (sel i = 0..2):
  - `d_in` is copied to `di_out`.
  - `full_out[i]` is set to 1.
  - The other destinations are unchanged.
- Flag clear:
  - `ack_in[i]` = 1 clears `full_out[i]` next edge, unless the same cycle accepts a write to i.
  - A write wins: the flag stays 1 and the data is the new value.
  - Ack on an empty destination has no effect.
- Per-destination state machine, two states:
  - EMPTY -> FULL on an accepted write.
  - FULL -> EMPTY on ack with no write.
  - FULL -> FULL on a write, whether or not ack is asserted.
- Counter:
  - `count_out` increments by 1 per accepted transfer.
  - It wraps from 2^CNT_W-1 to 0 with no flag.
- `d_in` and `sel_in` are sampled only on accept. Changing them while not accepted has no effect.
- Reset:
  - All `di_out` = 0, `full_out` = 000, `count_out` = 0, `ovf_out` = 0.
  - Reset takes precedence over a simultaneous accept or ack.
  - Asserting `rst` mid-stall drops the stalled transfer. The source must re-offer it.

## Timing
- `ready_out` is combinational from `valid_in`, `sel_in`, `full_out` and `ack_in`. There is no path from `d_in`.
- Write latency is 1 cycle: data accepted at edge N is visible on `di_out` and `full_out[i]` after edge N.
- Throughput is 1 transfer per cycle when targets are empty or acked in the same cycle.
- Holding registers do not change except on accept or reset.

## Configuration
- Macro: `DEMUX3_STALL_EN`.
- Defined (back-pressure mode):
  - `ready_out` = 0 when `valid_in` && sel != 11 && `full_out[sel]` && !`ack_in[sel]`; otherwise `ready_out` = 1.
  - The source holds `valid_in`, `sel_in` and `d_in` until accepted.
  - No data is ever lost. The `ovf_out` port is absent.
- Undefined (overwrite mode):
  - `ready_out` is tied to 1.
  - A write to a destination with `full_out[i]` = 1 and `ack_in[i]` = 0 overwrites the register.
  - That write pulses `ovf_out` = 1 for exactly the cycle after the edge.
  - Otherwise `ovf_out` = 0.

## Test plan
- Reset, then write 0x1234 to sel 00 → `d0_out` = 0x1234, `full_out` = 001, `count_out` = 1. `d1_out` and `d2_out` stay 0.
- sel 11 with data 0xFFFF, valid for 3 cycles → no register changes, `full_out` unchanged, `count_out` +3.
- Fill d1 with 0xAAAA, then offer 0x5555 to sel 01 without ack:
  - Stall build: `ready_out` = 0 until `ack_in` = 010. Write completes in the ack cycle; `d1_out` = 0x5555, `full_out[1]` = 1.
  - Overwrite build: `d1_out` = 0x5555 after 1 cycle, `ovf_out` one-cycle pulse.
- Same-cycle write and ack to d2 (full) with 0x0F0F → accepted with no stall, `d2_out` = 0x0F0F, `full_out[2]` stays 1, no `ovf_out`.
- 256 accepted transfers from count 0 with CNT_W = 8 → `count_out` returns to 0.
- `rst` asserted during a stalled write to d0 (stall build) → next cycle all outputs at reset values, `ready_out` = 1. The transfer is not written.
